// File: rtl/face_seq_pkg.sv
// rtl/face_seq_pkg.sv - shared types and constants for the FACE instruction sequencer
package face_seq_pkg;

    localparam logic [6:0]  SYSOPCODE  = 7'h0B;
    localparam logic [6:0]  SHAOPCODE  = 7'h2B;
    localparam logic [31:0] NOP_WORD   = 32'h0;

    localparam logic [2:0]  FUNC_FENCE = 3'd0;
    localparam logic [2:0]  FUNC_END   = 3'd1;
    localparam logic [2:0]  FUNC_WAIT  = 3'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_RDWAIT,
        S_DECODE,
        S_HAZARD,
        S_ISSUE,
        S_FENCE,
        S_DELAY,
        S_ADV,
        S_DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_SYS,
        CLS_SHA,
        CLS_SEQ,
        CLS_ILL
    } word_cls_t;

endpackage

// File: rtl/face_seq_ctrl_if.sv
// rtl/face_seq_ctrl_if.sv - program BRAM and FACE instruction bus seen by the sequencer
interface face_seq_ctrl_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     face_instr;
    logic            face_next_instr;
    logic [3:0]      face_bitbusy;

    modport master (
        output imem_addr,
        output face_instr,
        output face_next_instr,
        input  imem_rdata,
        input  face_bitbusy
    );

    modport slave (
        input  imem_addr,
        input  face_instr,
        input  face_next_instr,
        output imem_rdata,
        output face_bitbusy
    );
endinterface

// File: rtl/face_seq_decode.sv
// rtl/face_seq_decode.sv - classifies a fetched program word for the sequencer FSM
module face_seq_decode
    import face_seq_pkg::*;
#(
    parameter logic [6:0] SEQ_OPCODE = 7'h7F
) (
    input  logic [31:0] ir,
    output word_cls_t   cls,
    output logic [2:0]  func
);

    always_comb begin
        func = ir[9:7];
        cls  = CLS_ILL;
        if (ir == NOP_WORD) begin
            cls = CLS_NOP;
        end else if (ir[6:0] == SYSOPCODE) begin
            cls = CLS_SYS;
        end else if (ir[6:0] == SHAOPCODE) begin
            cls = CLS_SHA;
        end else if (ir[6:0] == SEQ_OPCODE &&
                     (ir[9:7] == FUNC_FENCE || ir[9:7] == FUNC_END || ir[9:7] == FUNC_WAIT)) begin
            cls = CLS_SEQ;
        end
    end

endmodule

// File: rtl/face_seq_ctrl.sv
// rtl/face_seq_ctrl.sv - fetches program words and issues them to FACE one at a time
module face_seq_ctrl
    import face_seq_pkg::*;
#(
    parameter int         PC_W          = 16,
    parameter logic [6:0] SEQ_OPCODE    = 7'h7F,
    parameter int         GUARD         = 2,
    parameter bit         ALLOW_OVERLAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  prog_base,
    input  logic [PC_W-1:0]  prog_len,
    face_seq_ctrl_if.master  fbus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [PC_W-1:0]  pc,
    output logic [31:0]      stall_cnt
);

    localparam int              GW     = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam logic [GW-1:0]   G_LOAD = GW'(GUARD);
    localparam logic [GW-1:0]   G_ONE  = GW'(1);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    seq_state_t       state, nxt;
    logic [PC_W-1:0]  base_q, len_q, pc_inc;
    logic [31:0]      ir;
    logic [19:0]      delay_cnt;
    logic [GW-1:0]    guard_sys, guard_sha;
    word_cls_t        cls;
    logic [2:0]       func;
    logic             sys_idle, sha_idle, both_idle, hazard_ok;
    logic             unused_bits;

    face_seq_decode #(.SEQ_OPCODE(SEQ_OPCODE)) u_decode (
        .ir   (ir),
        .cls  (cls),
        .func (func)
    );

    assign unused_bits = fbus.face_bitbusy[3] ^ fbus.face_bitbusy[0];
    assign pc_inc      = pc + PC_ONE;
    assign busy        = (state != S_IDLE);

    // An engine counts as idle only once its guard has covered the busy-rise latency.
    assign sys_idle  = !fbus.face_bitbusy[2] && (guard_sys == '0);
    assign sha_idle  = !fbus.face_bitbusy[1] && (guard_sha == '0);
    assign both_idle = sys_idle && sha_idle;
    assign hazard_ok = ALLOW_OVERLAP ? ((cls == CLS_SYS) ? sys_idle : sha_idle) : both_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt                  = state;
        fbus.imem_addr       = '0;
        fbus.face_instr      = NOP_WORD;
        fbus.face_next_instr = 1'b0;
        done                 = 1'b0;
        case (state)
            S_IDLE:   if (start) nxt = (prog_len == '0) ? S_DONE : S_FETCH;
            S_FETCH: begin
                fbus.imem_addr = base_q + pc;
                nxt            = S_RDWAIT;
            end
            S_RDWAIT: nxt = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_SYS, CLS_SHA: nxt = S_HAZARD;
                    CLS_NOP:          nxt = S_ADV;
                    CLS_SEQ: begin
                        if (func == FUNC_FENCE)      nxt = S_FENCE;
                        else if (func == FUNC_END)   nxt = S_DONE;
                        else if (ir[31:12] == '0)    nxt = S_ADV;
                        else                         nxt = S_DELAY;
                    end
                    default:          nxt = S_IDLE;
                endcase
            end
            S_HAZARD: if (hazard_ok) nxt = S_ISSUE;
            S_ISSUE: begin
                fbus.face_instr      = ir;
                fbus.face_next_instr = 1'b1;
                nxt                  = S_ADV;
            end
            S_FENCE:  if (both_idle) nxt = S_ADV;
            S_DELAY:  if (delay_cnt <= 20'd1) nxt = S_ADV;
            S_ADV:    nxt = (pc_inc == len_q) ? S_DONE : S_FETCH;
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default:  nxt = S_IDLE;
        endcase
        if (abort) begin
            nxt                  = S_IDLE;
            fbus.face_instr      = NOP_WORD;
            fbus.face_next_instr = 1'b0;
            done                 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            pc        <= '0;
            ir        <= NOP_WORD;
            delay_cnt <= '0;
            guard_sys <= '0;
            guard_sha <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (guard_sys != '0) guard_sys <= guard_sys - G_ONE;
            if (guard_sha != '0) guard_sha <= guard_sha - G_ONE;
            if (state == S_IDLE && start && !abort) begin
                base_q    <= prog_base;
                len_q     <= prog_len;
                pc        <= '0;
                err       <= 1'b0;
                stall_cnt <= '0;
            end
            if (state == S_RDWAIT && !abort) ir <= fbus.imem_rdata;
            if (state == S_DECODE && !abort) begin
                delay_cnt <= ir[31:12];
                if (cls == CLS_ILL) err <= 1'b1;
            end
            if (state == S_DELAY && delay_cnt != '0) delay_cnt <= delay_cnt - 20'd1;
            if (state == S_HAZARD && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (state == S_ISSUE && !abort) begin
                if (cls == CLS_SYS) guard_sys <= G_LOAD;
                else                guard_sha <= G_LOAD;
            end
            if (state == S_ADV && !abort) pc <= pc_inc;
        end
    end

endmodule

// File: tb/tb_face_seq_ctrl.sv
// tb/tb_face_seq_ctrl.sv - directed self-checking bench for face_seq_ctrl
module tb_face_seq_ctrl;

    localparam logic [31:0] W_ADDRSET = 32'h0000_100B;
    localparam logic [31:0] W_CALC    = 32'h0000_200B;
    localparam logic [31:0] W_SEED    = 32'h0000_102B;
    localparam logic [31:0] W_END     = 32'h0000_00FF;
    localparam logic [31:0] W_FENCE   = 32'h0000_007F;
    localparam logic [31:0] W_WAIT7   = 32'h0000_717F;
    localparam logic [31:0] W_ILL     = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [15:0] prog_base, prog_len, pc;
    logic        busy, done, err;
    logic [31:0] stall_cnt;

    logic [31:0] imem [0:63];
    logic [31:0] issued [0:7];
    int          n_issued, n_done, n_imem, n_stray, n_busy_issue;
    int          cyc, done_cyc, last_issue_cyc;
    logic [31:0] sys_word, sha_word;
    int          sys_len, sha_len, sys_cnt, sha_cnt;
    logic [3:0]  bb_force;
    int          n_checks, n_pass, n_fail;

    face_seq_ctrl_if #(.PC_W(16)) ifc ();

    face_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .prog_base (prog_base),
        .prog_len  (prog_len),
        .fbus      (ifc),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc        (pc),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ifc.imem_rdata <= imem[ifc.imem_addr[5:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: observe the bus, then drive engine busy for the cycle just entered.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ifc.face_next_instr) begin
            if (n_issued < 8) issued[n_issued] = ifc.face_instr;
            n_issued++;
            last_issue_cyc = cyc;
            if (ifc.face_bitbusy[2] || ifc.face_bitbusy[1]) n_busy_issue++;
        end else if (ifc.face_instr !== 32'h0) begin
            n_stray++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (ifc.imem_addr != 16'h0) n_imem++;
        ifc.face_bitbusy = bb_force | {1'b0, sys_cnt != 0, sha_cnt != 0, 1'b0};
        if (sys_cnt != 0) sys_cnt--;
        if (sha_cnt != 0) sha_cnt--;
        if (ifc.face_next_instr && ifc.face_instr == sys_word) sys_cnt = sys_len;
        if (ifc.face_next_instr && ifc.face_instr == sha_word) sha_cnt = sha_len;
    endtask

    task automatic reset_obs();
        for (int i = 0; i < 8; i++) issued[i] = 32'hDEAD_BEEF;
        n_issued = 0; n_done = 0; n_imem = 0; n_stray = 0; n_busy_issue = 0;
        cyc = 0; done_cyc = -1; last_issue_cyc = -1;
    endtask

    task automatic launch(input logic [15:0] base, input logic [15:0] len);
        reset_obs();
        prog_base = base;
        prog_len  = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_to_idle();
        while (busy && cyc < 200) tick();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        prog_base = '0; prog_len = '0;
        bb_force = 4'h0; sys_cnt = 0; sha_cnt = 0;
        sys_word = 32'h0; sha_word = 32'h0; sys_len = 0; sha_len = 0;
        ifc.face_bitbusy = 4'h0;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[8]  = W_ADDRSET; imem[9]  = W_CALC;  imem[10] = W_END;
        imem[16] = W_SEED;    imem[17] = W_CALC;
        imem[24] = W_WAIT7;   imem[25] = W_FENCE; imem[26] = W_END;
        imem[32] = W_ADDRSET; imem[33] = W_ILL;   imem[34] = W_END;
        imem[48] = 32'h0;     imem[49] = W_ADDRSET; imem[50] = 32'h0;
        imem[56] = W_CALC;    imem[57] = W_END;
        reset_obs();

        repeat (3) @(negedge clk);
        chk("rst_flags", {28'h0, busy, done, err, ifc.face_next_instr}, 32'h0);
        chk("rst_pc", pc, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_instr", ifc.face_instr, 32'h0);
        chk("rst_imem_addr", ifc.imem_addr, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // addrset, calc, END with systolic busy 20 cycles after calc
        sys_word = W_CALC; sys_len = 20;
        launch(16'd8, 16'd3);
        run_to_idle();
        chk("t1_idle_cyc", cyc, 17);
        chk("t1_n_issued", n_issued, 2);
        chk("t1_issue0", issued[0], W_ADDRSET);
        chk("t1_issue1", issued[1], W_CALC);
        chk("t1_calc_cyc", last_issue_cyc, 11);
        chk("t1_n_done", n_done, 1);
        chk("t1_done_cyc", done_cyc, 16);
        chk("t1_stray", n_stray, 0);
        chk("t1_stall", stall_cnt, 2);
        chk("t1_pc", pc, 2);
        repeat (25) tick();
        sys_word = 32'h0;

        // SHA seedset then SYS calc; SHA busy stalls the calc
        sha_word = W_SEED; sha_len = 14;
        launch(16'd16, 16'd2);
        run_to_idle();
        chk("t2_idle_cyc", cyc, 24);
        chk("t2_n_issued", n_issued, 2);
        chk("t2_issue1", issued[1], W_CALC);
        chk("t2_calc_cyc", last_issue_cyc, 21);
        chk("t2_busy_issue", n_busy_issue, 0);
        chk("t2_stall", stall_cnt, 12);
        chk("t2_done_cyc", done_cyc, 20 + 3);
        repeat (25) tick();
        sha_word = 32'h0;

        // WAIT 7, FENCE, END: nothing forwarded
        launch(16'd24, 16'd3);
        run_to_idle();
        chk("t3_idle_cyc", cyc, 21);
        chk("t3_done_cyc", done_cyc, 20);
        chk("t3_n_issued", n_issued, 0);
        chk("t3_stray", n_stray, 0);
        chk("t3_pc", pc, 2);
        repeat (5) tick();

        // illegal word at pc 1
        launch(16'd32, 16'd3);
        run_to_idle();
        chk("t4_idle_cyc", cyc, 10);
        chk("t4_err", err, 1);
        chk("t4_n_done", n_done, 0);
        chk("t4_n_issued", n_issued, 1);
        chk("t4_stray", n_stray, 0);
        chk("t4_pc", pc, 1);
        repeat (5) tick();

        // empty program; err from previous run is cleared
        launch(16'd40, 16'd0);
        chk("t5a_done_now", done, 1);
        chk("t5a_err_clr", err, 0);
        run_to_idle();
        chk("t5a_idle_cyc", cyc, 2);
        chk("t5a_n_done", n_done, 1);
        chk("t5a_imem", n_imem, 0);
        repeat (3) tick();

        // three words without END: implicit finish
        launch(16'd48, 16'd3);
        run_to_idle();
        chk("t5b_done_cyc", done_cyc, 15);
        chk("t5b_n_done", n_done, 1);
        chk("t5b_n_issued", n_issued, 1);
        chk("t5b_imem", n_imem, 3);
        chk("t5b_pc", pc, 3);
        repeat (3) tick();

        // abort while stalled in HAZARD, then rerun
        bb_force = 4'b0100;
        tick();
        launch(16'd56, 16'd2);
        repeat (5) tick();
        chk("t6_busy_before", busy, 1);
        abort = 1'b1;
        chk("t6_abort_instr", ifc.face_instr, 32'h0);
        chk("t6_abort_next", ifc.face_next_instr, 0);
        tick();
        abort = 1'b0;
        chk("t6_idle_after", busy, 0);
        chk("t6_stall", stall_cnt, 3);
        chk("t6_n_done", n_done, 0);
        chk("t6_n_issued", n_issued, 0);
        bb_force = 4'h0;
        repeat (3) tick();
        launch(16'd56, 16'd2);
        chk("t6_rerun_addr", ifc.imem_addr, 56);
        chk("t6_rerun_stall", stall_cnt, 0);
        chk("t6_rerun_err", err, 0);
        run_to_idle();
        chk("t6_rerun_done_cyc", done_cyc, 10);
        chk("t6_rerun_issue", issued[0], W_CALC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
